// File: rtl/w_fifo_drain.sv
// Read side of the W-channel crossing: pops beats from w_fifo and drives an AXI4
// W master port. Beats are released only against burst lengths accepted from the
// AW side, and WLAST is regenerated from a per-burst beat count.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A valid, once raised, stays high with its payload unchanged until
// that edge. The len_* pair follows the same rule. fifo_pop is a combinational
// request that the w_fifo front is consumed at the coming edge.
`timescale 1ns/1ps
module w_fifo_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int LEN_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  len_valid,
  input  logic [7:0]            len_data,
  output logic                  len_ready,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_WDATA,
  input  logic [STRB_WIDTH-1:0] fifo_WSTRB,
  input  logic                  fifo_WLAST,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic                  last_err,
  input  logic                  err_clr,
  output logic                  burst_busy,
  output logic                  dbg_state
);

  localparam int PW = $clog2(LEN_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  // Length queue: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  len_mem_q [LEN_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic        q_empty, q_full, q_push, q_pop;
  logic [7:0]  q_head;

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    wlast_q;
  logic                    wvalid_q;
  logic                    err_q;
  logic                    last_beat;
  logic                    issue;

  assign q_empty   = (wr_ptr_q == rd_ptr_q);
  assign q_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign q_head    = len_mem_q[rd_ptr_q[PW-1:0]];
  // No bypass: a full queue refuses even when it is being popped this cycle.
  assign len_ready = !q_full;
  assign q_push    = len_valid && !q_full;

  assign last_beat = (cnt_q == 8'd0);
  // A beat moves only in BURST, when w_fifo has one and the output slot frees.
  assign issue     = (state_q == BURST) && !fifo_empty && (!wvalid_q || WREADY);
  // Head is consumed when a burst starts from IDLE or chains after the last beat.
  assign q_pop     = !q_empty && ((state_q == IDLE) || (issue && last_beat));

  assign fifo_pop   = issue;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign WLAST      = wlast_q;
  assign WVALID     = wvalid_q;
  assign last_err   = err_q;
  assign burst_busy = (state_q == BURST) || wvalid_q;
  assign dbg_state  = state_q;

  // Length storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (q_push) len_mem_q[wr_ptr_q[PW-1:0]] <= len_data;
  end

  // Length queue pointers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (q_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Burst FSM: cnt holds beats remaining minus one; chains bursts without a bubble.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!q_empty) begin
            cnt_q   <= q_head;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            if (!last_beat) begin
              cnt_q <= cnt_q - 8'd1;
            end else if (!q_empty) begin
              cnt_q <= q_head;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: load on issue, drop valid only after an unreplaced handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (issue) begin
      wdata_q  <= fifo_WDATA;
      wstrb_q  <= fifo_WSTRB;
      wlast_q  <= last_beat;
      wvalid_q <= 1'b1;
    end else if (wvalid_q && WREADY) begin
      wvalid_q <= 1'b0;
    end
  end

  // Sticky flag for a carried WLAST that disagrees with the count; set beats clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (issue && (fifo_WLAST != last_beat)) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

endmodule
